ahb_rr_burst_arbiter: RTL and testbench
=======================================

// Module: ahb_rr_burst_arbiter
// PURPOSE
//  Round-robin AHB-lite bus arbiter for N masters sharing one address/data path.
//  Burst-aware: tracks beats of the address-phase owner and hands over only at burst ends.
//  Honours HLOCK, caps undefined-length INCR bursts and parks the bus on a default master.
//  Drives hgrant and the address-phase owner index consumed by the master/slave mux.
// PARAMETERS
//  MASTER_NUM     4             number of masters (2..16)
//  DEFAULT_MASTER MASTER_NUM-1  parked owner when nobody requests
//  MAX_INCR_BEATS 16            beats an INCR (undefined) burst may hold the bus
//  IDX_W          $clog2(MASTER_NUM)  width of master index (derived, not overridden)
// PORTS
//  hclk          in   1              clock, rising edge
//  hreset        in   1              reset, asynchronous, active-low
//  m_busreq      in   MASTER_NUM     bus request per master
//  m_hlock       in   MASTER_NUM     lock request per master
//  m_htrans      in   2*MASTER_NUM   HTRANS per master, master i at [2i+:2]
//  m_hburst      in   3*MASTER_NUM   HBURST per master, master i at [3i+:3]
//  hready        in   1              muxed HREADY from the data-phase slave
//  hgrant        out  MASTER_NUM     one-hot grant, registered
//  hmaster       out  IDX_W          address-phase owner, registered
//  hmaster_lock  out  1              address-phase owner is locked, registered
// BEHAVIOUR
//  Reset (async, hreset=0):
//   hgrant=1<<DEFAULT_MASTER, hmaster=DEFAULT_MASTER, hmaster_lock=0.
//   State=PARK, beat counter=0, rr_last=DEFAULT_MASTER.
//  Freeze: when hready=0, no register changes, including grant, counter, state and rr_last.
//  Beat: hready=1 and m_htrans[hmaster] is NONSEQ or SEQ. BUSY and IDLE are never beats.
//  NONSEQ beat: loads remaining = len-1.
//   len: SINGLE=1; INCR4/WRAP4=4; INCR8/WRAP8=8; INCR16/WRAP16=16; INCR=MAX_INCR_BEATS.
//  SEQ beat: remaining decrements, saturating at 0.
//  States (grantee = index of hgrant):
//   PARK : grantee is DEFAULT_MASTER and no busreq. Arbitrates every hready=1 cycle.
//   OWN  : grantee owns the bus with no burst open. Arbitrates when hready=1 and the grantee's busreq=0 or its htrans=IDLE.
//   BURST: entered on a NONSEQ beat with len>1. Arbitration point is the beat that leaves remaining==1.
//          New grantee sees hgrant during the last beat's address phase: zero-bubble handover.
//   LOCK : entered when grantee has busreq&hlock at an arbitration point. No arbitration until hready=1 with busreq or hlock of grantee low.
//  SINGLE and INCR end: arbitration on the final beat itself, with one IDLE bubble accepted.
//  IDLE during BURST (early termination): remaining<=0, state->OWN.
//  Arbitration: winner is the first requester scanning (rr_last+1)..(rr_last+N) mod N.
//   hgrant<=1<<winner and rr_last<=winner on that edge.
//   No requester: winner=DEFAULT_MASTER, state->PARK, rr_last unchanged.
//   Grantee's own busreq counts, so a lone requester is re-granted with no gap.
//  Handover: on hready=1, hmaster<=grantee and hmaster_lock<=m_hlock[grantee]. hmaster lags hgrant by >=1 cycle.
//  Priority at a given cycle: LOCK hold > burst-in-progress hold > round robin.
//   Burst end with hlock still high: grantee is retained.
//  Lock hold beats the INCR cap: INCR cap is ignored while in LOCK.
//  Reset mid-burst: all state returns to reset values immediately, with no partial handover.
// STRUCTURE
//  integration_pkg adds:
//   htrans_t {IDLE,BUSY,NONSEQ,SEQ}
//   hburst_t {SINGLE,INCR,WRAP4,INCR4,WRAP8,INCR8,WRAP16,INCR16}
//   arb_state_t {PARK,OWN,BURST,LOCK}
//   function burst_len(hburst_t,max_incr)
//  Sub-module rr_priority_picker #(N): combinational, inputs req[N] and last[IDX_W], outputs winner and any_req.
//  Top holds the FSM, beat counter and output registers.
// TESTING
//  T1 reset: hreset=0 mid-traffic -> hgrant=4'b1000, hmaster=3, hmaster_lock=0 on the same cycle.
//  T2 round robin: busreq=4'b1111 with SINGLE NONSEQs, hready=1 -> winners 0,1,2,3,0 in order.
//  T3 INCR4, m1 vs pending m2: m1 beat1 NONSEQ then SEQ x3.
//     hgrant flips to m2 on the edge after beat3 (remaining 1).
//     hmaster=2 on the edge after beat4, with no IDLE cycle.
//  T4 lock: m0 busreq=hlock=1 with 3 INCR4 bursts while m1 requests.
//     hgrant stays 4'b0001 and hmaster_lock=1.
//     m1 is granted 1 cycle after m0 drops hlock.
//  T5 wait states: hready=0 for 5 cycles during the last beat of WRAP8.
//     remaining, hgrant and hmaster are frozen.
//     Handover completes on the first hready=1 edge.
//  T6 INCR cap and early IDLE:
//     m2 INCR with MAX_INCR_BEATS=16 and m3 requesting -> grant moves after beat 16.
//     m2 IDLE after 2 beats of INCR8 -> state OWN, and re-arbitration that cycle.

Source files
------------

// File: rtl/ahb_rr_burst_arbiter_pkg.sv
// ahb_rr_burst_arbiter_pkg: AHB transfer/burst encodings and arbiter state type
package ahb_rr_burst_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, NONSEQ, SEQ} htrans_t;
  typedef enum logic [2:0] {SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16} hburst_t;
  typedef enum logic [1:0] {PARK, OWN, BURST, LOCK} arb_state_t;
  function automatic int burst_len(hburst_t b, int max_incr);
    return b == SINGLE ? 1 : b == INCR ? max_incr :
           (b == WRAP4 || b == INCR4) ? 4 : (b == WRAP8 || b == INCR8) ? 8 : 16;
  endfunction
endpackage

// File: rtl/ahb_rr_burst_arbiter_rr_priority_picker.sv
// rr_priority_picker: first requester after last, scanning upward modulo N
module rr_priority_picker #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] winner,
  output logic         any_req
);
  // Scan from the farthest offset down so the nearest requester is written last.
  always_comb begin
    winner = '0;
    for (int k = N; k >= 1; k--) if (req[(int'(last) + k) % N]) winner = W'((int'(last) + k) % N);
  end
  assign any_req = |req;
endmodule

// File: rtl/ahb_rr_burst_arbiter.sv
// ahb_rr_burst_arbiter: burst-aware round-robin AHB-lite arbiter with lock and parking
module ahb_rr_burst_arbiter
  import ahb_rr_burst_arbiter_pkg::*;
#(
  parameter int MASTER_NUM = 4,
  parameter int DEFAULT_MASTER = MASTER_NUM - 1,
  parameter int MAX_INCR_BEATS = 16,
  localparam int IDX_W = $clog2(MASTER_NUM)
) (
  input  logic                    hclk,
  input  logic                    hreset,
  input  logic [MASTER_NUM-1:0]   m_busreq,
  input  logic [MASTER_NUM-1:0]   m_hlock,
  input  logic [2*MASTER_NUM-1:0] m_htrans,
  input  logic [3*MASTER_NUM-1:0] m_hburst,
  input  logic                    hready,
  output logic [MASTER_NUM-1:0]   hgrant,
  output logic [IDX_W-1:0]        hmaster,
  output logic                    hmaster_lock
);
  localparam int RW = $clog2(MAX_INCR_BEATS > 16 ? MAX_INCR_BEATS : 16);
  localparam logic [IDX_W-1:0] DEF = IDX_W'(DEFAULT_MASTER);
  arb_state_t state, state_n;
  htrans_t tr;
  hburst_t hb;
  int len;
  logic [RW-1:0] rem, rem_n;
  logic undef, undef_n;
  logic [IDX_W-1:0] rr_last, last_n, g, winner;
  logic [MASTER_NUM-1:0] grant_n;
  logic any_req, hm_own, ns, sq, idle, fin, open, lk, lkw, arb;
  rr_priority_picker #(.N(MASTER_NUM)) u_pick (.req(m_busreq), .last(rr_last), .winner(winner), .any_req(any_req));
  always_comb begin
    g = '0;
    for (int k = 0; k < MASTER_NUM; k++) if (hgrant[k]) g = IDX_W'(k);
  end
  // Beat tracking follows the address-phase owner, not the grantee.
  assign tr = htrans_t'(m_htrans[2*int'(hmaster) +: 2]);
  assign hb = hburst_t'(m_hburst[3*int'(hmaster) +: 3]);
  assign len = burst_len(hb, MAX_INCR_BEATS);
  assign ns = tr == NONSEQ;
  assign sq = tr == SEQ;
  assign idle = tr == IDLE;
  assign hm_own = hmaster == g;
  assign rem_n = ns ? RW'(len - 1) : sq ? (rem == '0 ? '0 : rem - 1'b1) : idle ? '0 : rem;
  assign undef_n = ns ? hb == INCR : undef;
  // Fixed bursts hand over one beat early; SINGLE and capped INCR on their final beat.
  assign fin = (ns | sq) & (rem_n == '0 ? (undef_n | ns) : (rem_n == RW'(1) & !undef_n));
  assign open = hm_own & (undef_n ? rem_n != '0 : rem_n > RW'(1));
  assign lk = m_busreq[g] & m_hlock[g];
  assign lkw = m_busreq[winner] & m_hlock[winner];
  assign arb = (state == PARK) | ((state == OWN) & (!m_busreq[g] | (hm_own & (idle | fin)))) |
               ((state == BURST) & hm_own & (idle | fin)) | ((state == LOCK) & !lk & !open);
  always_comb begin
    state_n = state;
    grant_n = hgrant;
    last_n = rr_last;
    if (arb) begin
      if (lk) state_n = LOCK;
      else begin
        grant_n = any_req ? MASTER_NUM'(1) << winner : MASTER_NUM'(1) << DEF;
        last_n = any_req ? winner : rr_last;
        state_n = !any_req ? PARK : lkw ? LOCK : OWN;
      end
    end else if (state == LOCK) state_n = lk ? LOCK : BURST;
    else if (hm_own & ns & len > 1) state_n = BURST;
  end
  always_ff @(posedge hclk or negedge hreset) begin
    if (!hreset) begin
      state <= PARK;
      hgrant <= MASTER_NUM'(1) << DEF;
      rr_last <= DEF;
      rem <= '0;
      undef <= 1'b0;
      hmaster <= DEF;
      hmaster_lock <= 1'b0;
    end else if (hready) begin
      state <= state_n;
      hgrant <= grant_n;
      rr_last <= last_n;
      rem <= rem_n;
      undef <= undef_n;
      hmaster <= g;
      hmaster_lock <= m_hlock[g];
    end
  end
endmodule

// File: tb/tb_ahb_rr_burst_arbiter.sv
// tb_ahb_rr_burst_arbiter: scoreboard bench checking grant/owner changes and their cycles
module tb_ahb_rr_burst_arbiter;
  import ahb_rr_burst_arbiter_pkg::*;
  logic hclk = 0, hreset = 0, hready = 1;
  logic [3:0] m_busreq = '0, m_hlock = '0;
  logic [7:0] m_htrans = '0;
  logic [11:0] m_hburst = '0;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic hmaster_lock;
  int cyc = 0, checks = 0, errors = 0, c;
  typedef struct {int c; logic [6:0] v; string n;} exp_t;
  exp_t sb[$];
  logic [6:0] prev = 7'h7f;
  ahb_rr_burst_arbiter dut (.hclk(hclk), .hreset(hreset), .m_busreq(m_busreq), .m_hlock(m_hlock),
    .m_htrans(m_htrans), .m_hburst(m_hburst), .hready(hready), .hgrant(hgrant), .hmaster(hmaster),
    .hmaster_lock(hmaster_lock));
  always #5 hclk = ~hclk;
  always @(posedge hclk) cyc <= cyc + 1;
  // Every change of {hgrant,hmaster,hmaster_lock} must match the next expected entry and cycle.
  always @(negedge hclk) begin
    logic [6:0] cur;
    exp_t e;
    cur = {hgrant, hmaster, hmaster_lock};
    if (cur !== prev) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected: got %b at cyc %0d, want no change", cur, cyc);
      end else begin
        e = sb.pop_front();
        if (cur !== e.v || (e.c >= 0 && e.c != cyc)) begin
          errors++;
          $display("FAIL %s: got %b at cyc %0d, want %b at cyc %0d", e.n, cur, cyc, e.v, e.c);
        end
      end
      prev = cur;
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge hclk);
    #1;
  endtask
  task automatic drive(input logic [3:0] r, input logic [3:0] l, input htrans_t t, input hburst_t b);
    m_busreq = r;
    m_hlock = l;
    m_htrans = {4{t}};
    m_hburst = {4{b}};
  endtask
  task automatic push(input int cc, input logic [3:0] g, input logic [1:0] h, input logic l, input string n);
    sb.push_back('{cc, {g, h, l}, n});
  endtask
  initial begin
    push(-1, 4'b1000, 2'd3, 1'b0, "reset");
    drive(4'b0000, 4'b0000, IDLE, SINGLE);
    step(2);
    hreset = 1;
    step(2);
    // T2 round robin of SINGLE transfers
    c = cyc;
    for (int k = 0; k < 5; k++) begin
      push(c + 1 + 2*k, 4'b0001 << (k % 4), 2'((k + 3) % 4), 1'b0, "rr_grant");
      push(c + 2 + 2*k, 4'b0001 << (k % 4), 2'(k % 4), 1'b0, "rr_owner");
    end
    drive(4'b1111, 4'b0000, NONSEQ, SINGLE);
    step(10);
    push(c + 11, 4'b1000, 2'd0, 1'b0, "rr_park");
    push(c + 12, 4'b1000, 2'd3, 1'b0, "rr_park_owner");
    drive(4'b0000, 4'b0000, IDLE, SINGLE);
    step(3);
    // T3 INCR4 on m1 with m2 pending: zero-bubble handover
    c = cyc;
    push(c + 1, 4'b0010, 2'd3, 1'b0, "t3_grant1");
    push(c + 2, 4'b0010, 2'd1, 1'b0, "t3_owner1");
    push(c + 5, 4'b0100, 2'd1, 1'b0, "t3_grant2_after_beat3");
    push(c + 6, 4'b0100, 2'd2, 1'b0, "t3_owner2_after_beat4");
    push(c + 7, 4'b1000, 2'd2, 1'b0, "t3_park");
    push(c + 8, 4'b1000, 2'd3, 1'b0, "t3_park_owner");
    drive(4'b0010, 4'b0000, IDLE, INCR4);
    step(2);
    drive(4'b0110, 4'b0000, NONSEQ, INCR4);
    step(1);
    drive(4'b0110, 4'b0000, SEQ, INCR4);
    step(3);
    drive(4'b0000, 4'b0000, IDLE, INCR4);
    step(3);
    // T4 locked m0 keeps the bus over three INCR4 bursts
    c = cyc;
    push(c + 1, 4'b0001, 2'd3, 1'b0, "t4_grant0");
    push(c + 2, 4'b0001, 2'd0, 1'b1, "t4_owner0_locked");
    push(c + 16, 4'b0010, 2'd0, 1'b0, "t4_grant1_after_unlock");
    push(c + 17, 4'b0010, 2'd1, 1'b0, "t4_owner1");
    push(c + 18, 4'b1000, 2'd1, 1'b0, "t4_park");
    push(c + 19, 4'b1000, 2'd3, 1'b0, "t4_park_owner");
    drive(4'b0011, 4'b0001, IDLE, INCR4);
    step(2);
    for (int b = 0; b < 3; b++) begin
      drive(4'b0011, 4'b0001, NONSEQ, INCR4);
      step(1);
      drive(4'b0011, 4'b0001, SEQ, INCR4);
      step(3);
    end
    drive(4'b0011, 4'b0001, IDLE, INCR4);
    step(1);
    drive(4'b0011, 4'b0000, IDLE, INCR4);
    step(2);
    drive(4'b0000, 4'b0000, IDLE, INCR4);
    step(3);
    // T5 WRAP8 on m2, five wait states on the last beat
    c = cyc;
    push(c + 1, 4'b0100, 2'd3, 1'b0, "t5_grant2");
    push(c + 2, 4'b0100, 2'd2, 1'b0, "t5_owner2");
    push(c + 9, 4'b1000, 2'd2, 1'b0, "t5_grant3_after_beat7");
    push(c + 15, 4'b1000, 2'd3, 1'b0, "t5_owner3_after_wait");
    drive(4'b0100, 4'b0000, IDLE, WRAP8);
    step(2);
    drive(4'b1100, 4'b0000, NONSEQ, WRAP8);
    step(1);
    drive(4'b1100, 4'b0000, SEQ, WRAP8);
    step(6);
    hready = 0;
    step(5);
    hready = 1;
    step(1);
    drive(4'b0000, 4'b0000, IDLE, WRAP8);
    step(3);
    // T6a INCR on m2 capped at 16 beats with m3 requesting
    c = cyc;
    push(c + 1, 4'b0100, 2'd3, 1'b0, "t6a_grant2");
    push(c + 2, 4'b0100, 2'd2, 1'b0, "t6a_owner2");
    push(c + 18, 4'b1000, 2'd2, 1'b0, "t6a_grant3_after_beat16");
    push(c + 19, 4'b1000, 2'd3, 1'b0, "t6a_owner3");
    drive(4'b0100, 4'b0000, IDLE, INCR);
    step(2);
    drive(4'b1100, 4'b0000, NONSEQ, INCR);
    step(1);
    drive(4'b1100, 4'b0000, SEQ, INCR);
    step(15);
    drive(4'b1000, 4'b0000, IDLE, INCR);
    step(1);
    drive(4'b0000, 4'b0000, IDLE, INCR);
    step(3);
    // T6b INCR8 on m2 ended by IDLE after two beats
    c = cyc;
    push(c + 1, 4'b0100, 2'd3, 1'b0, "t6b_grant2");
    push(c + 2, 4'b0100, 2'd2, 1'b0, "t6b_owner2");
    push(c + 5, 4'b1000, 2'd2, 1'b0, "t6b_grant3_on_idle");
    push(c + 6, 4'b1000, 2'd3, 1'b0, "t6b_owner3");
    drive(4'b0100, 4'b0000, IDLE, INCR8);
    step(2);
    drive(4'b1100, 4'b0000, NONSEQ, INCR8);
    step(1);
    drive(4'b1100, 4'b0000, SEQ, INCR8);
    step(1);
    drive(4'b1100, 4'b0000, IDLE, INCR8);
    step(1);
    drive(4'b1000, 4'b0000, IDLE, INCR8);
    step(1);
    drive(4'b0000, 4'b0000, IDLE, INCR8);
    step(3);
    // T1 asynchronous reset in the middle of a locked burst
    c = cyc;
    push(c + 1, 4'b0001, 2'd3, 1'b0, "t1_grant0");
    push(c + 2, 4'b0001, 2'd0, 1'b1, "t1_owner0_locked");
    push(c + 4, 4'b1000, 2'd3, 1'b0, "t1_async_reset");
    drive(4'b0001, 4'b0001, IDLE, INCR4);
    step(2);
    drive(4'b0001, 4'b0001, NONSEQ, INCR4);
    step(1);
    drive(4'b0001, 4'b0001, SEQ, INCR4);
    step(1);
    hreset = 0;
    drive(4'b0000, 4'b0000, IDLE, SINGLE);
    step(2);
    hreset = 1;
    step(2);
    // rr_last must have returned to the default master: m0 beats m1
    c = cyc;
    push(c + 1, 4'b0001, 2'd3, 1'b0, "rst_rr_grant0");
    push(c + 2, 4'b0001, 2'd0, 1'b0, "rst_rr_owner0");
    push(c + 3, 4'b1000, 2'd0, 1'b0, "rst_rr_park");
    push(c + 4, 4'b1000, 2'd3, 1'b0, "rst_rr_park_owner");
    drive(4'b0011, 4'b0000, IDLE, SINGLE);
    step(2);
    drive(4'b0000, 4'b0000, IDLE, SINGLE);
    step(6);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_changes: got %0d outstanding, want 0 (next %s)", sb.size(), sb[0].n);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
